// File: rtl/xbar_slot_scheduler_if.sv
// xbar_slot_scheduler_if: request, grant and fabric-select bundle around the slot scheduler
interface xbar_slot_scheduler_if;
  logic       start;
  logic       abort;
  logic [3:0] req_valid;
  logic [7:0] req_dest;
  logic [3:0] grant;
  logic [3:0] blocked;
  logic [3:0] out_vld;
  logic [7:0] out_sel;
  logic [3:0] slot;
  logic       busy;
  logic       frame_done;
  modport master (
    output start, abort, req_valid, req_dest,
    input  grant, blocked, out_vld, out_sel, slot, busy, frame_done
  );
  modport slave (
    input  start, abort, req_valid, req_dest,
    output grant, blocked, out_vld, out_sel, slot, busy, frame_done
  );
endinterface

// File: rtl/xbar_slot_scheduler.sv
// xbar_slot_scheduler: per-frame 4x4 crossbar slot scheduler and output arbiter.
// XBAR_SCHED_RR_EN selects round-robin per output; otherwise the lowest input wins.
module xbar_slot_scheduler #(
  parameter int NUM_SLOTS = 4
) (
  input logic                  clk,
  input logic                  rst,
  xbar_slot_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARB, ISSUE, DONE} state_t;
  state_t          state, state_nxt;
  logic [3:0]      slot_q;
  logic            last_slot;
  logic            load;
  logic [3:0][3:0] cand;
  logic [3:0][1:0] win;
  logic [3:0]      found;
  logic [3:0]      grant_nxt, blocked_nxt;
  logic [7:0]      out_sel_nxt;
  logic [3:0]      grant_q, blocked_q, out_vld_q;
  logic [7:0]      out_sel_q;
  assign last_slot = slot_q == 4'(NUM_SLOTS - 1);
  assign load      = state == ARB && state_nxt == ISSUE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = bus.start & ~bus.abort ? ARB : IDLE;
      ARB:     state_nxt = ISSUE;
      ISSUE:   state_nxt = last_slot ? DONE : ARB;
      default: state_nxt = IDLE;
    endcase
    if (bus.abort && state != IDLE) state_nxt = IDLE;
  end
  // slot reads 0 whenever the scheduler is idle, so every entry to IDLE clears it
  always_ff @(posedge clk or posedge rst)
    if (rst) slot_q <= '0;
    else     slot_q <= state_nxt == IDLE ? '0 :
                       state == ISSUE && state_nxt == ARB ? slot_q + 4'd1 : slot_q;
  always_comb begin
    cand = '0;
    for (int o = 0; o < 4; o++)
      for (int i = 0; i < 4; i++)
        cand[o][i] = bus.req_valid[i] & (bus.req_dest[2*i +: 2] == 2'(o));
  end
`ifdef XBAR_SCHED_RR_EN
  logic [3:0][1:0] ptr;
  // descending search so the candidate closest to ptr[o] is the last one written
  always_comb begin
    found = '0;
    win   = '0;
    for (int o = 0; o < 4; o++) begin
      found[o] = |cand[o];
      win[o]   = ptr[o];
      for (int k = 3; k >= 0; k--)
        if (cand[o][ptr[o] + 2'(k)]) win[o] = ptr[o] + 2'(k);
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= '0;
    else if (load)
      for (int o = 0; o < 4; o++)
        if (found[o]) ptr[o] <= win[o] + 2'd1;
`else
  always_comb begin
    found = '0;
    win   = '0;
    for (int o = 0; o < 4; o++) begin
      found[o] = |cand[o];
      for (int k = 3; k >= 0; k--)
        if (cand[o][k]) win[o] = 2'(k);
    end
  end
`endif
  always_comb begin
    grant_nxt   = '0;
    out_sel_nxt = '0;
    for (int i = 0; i < 4; i++)
      grant_nxt[i] = found[bus.req_dest[2*i +: 2]] & (win[bus.req_dest[2*i +: 2]] == 2'(i));
    for (int o = 0; o < 4; o++)
      out_sel_nxt[2*o +: 2] = found[o] ? win[o] : 2'd0;
    blocked_nxt = bus.req_valid & ~grant_nxt;
  end
  // issue outputs live for exactly the ISSUE cycle that follows ARB
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      grant_q   <= '0;
      blocked_q <= '0;
      out_vld_q <= '0;
      out_sel_q <= '0;
    end else begin
      grant_q   <= load ? grant_nxt : '0;
      blocked_q <= load ? blocked_nxt : '0;
      out_vld_q <= load ? found : '0;
      out_sel_q <= load ? out_sel_nxt : '0;
    end
  assign bus.grant      = grant_q;
  assign bus.blocked    = blocked_q;
  assign bus.out_vld    = out_vld_q;
  assign bus.out_sel    = out_sel_q;
  assign bus.slot       = slot_q;
  assign bus.busy       = state != IDLE;
  assign bus.frame_done = state == DONE;
endmodule

// File: tb/tb_xbar_slot_scheduler.sv
// tb_xbar_slot_scheduler: table and scoreboard bench for the crossbar slot scheduler
module tb_xbar_slot_scheduler;
  localparam int NS = 4;
`ifdef XBAR_SCHED_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  typedef struct {
    logic [3:0] rv;
    logic [7:0] rd;
    logic [3:0] g;
    logic [3:0] b;
    logic [3:0] ov;
    logic [7:0] os;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  vec_t sb_q[$];
  vec_t frm[NS];
  vec_t tbl[8];
  xbar_slot_scheduler_if bus();
  xbar_slot_scheduler #(.NUM_SLOTS(NS)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic chk_idle(input string nm);
    chk({nm, ".grant"}, 8'(bus.grant), 8'h0);
    chk({nm, ".blocked"}, 8'(bus.blocked), 8'h0);
    chk({nm, ".out_vld"}, 8'(bus.out_vld), 8'h0);
    chk({nm, ".out_sel"}, bus.out_sel, 8'h0);
    chk({nm, ".slot"}, 8'(bus.slot), 8'h0);
    chk({nm, ".busy"}, 8'(bus.busy), 8'h0);
    chk({nm, ".frame_done"}, 8'(bus.frame_done), 8'h0);
  endtask
  function automatic vec_t mk(logic [3:0] rv, logic [7:0] rd, logic [3:0] g, logic [3:0] b,
                              logic [3:0] ov, logic [7:0] os);
    vec_t v;
    v.rv = rv; v.rd = rd; v.g = g; v.b = b; v.ov = ov; v.os = os;
    return v;
  endfunction
  // all four inputs aimed at output 2, input w expected to win
  function automatic vec_t cont(int w);
    logic [3:0] g;
    g = 4'b0001 << w;
    return mk(4'hf, 8'hAA, g, ~g, 4'b0100, 8'(w << 4));
  endfunction
  function automatic int cw(int k, int base);
    return RR ? (base + k) % 4 : 0;
  endfunction
  // enters and leaves at a negedge; abort_at >= 0 aborts during that slot's ISSUE
  task automatic run_frame(input int abort_at);
    vec_t e;
    bus.start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < NS; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.req_valid = frm[k].rv;
      bus.req_dest = frm[k].rd;
      sb_q.push_back(frm[k]);
      chk("arb.busy", 8'(bus.busy), 8'h1);
      chk("arb.frame_done", 8'(bus.frame_done), 8'h0);
      chk("arb.grant", 8'(bus.grant), 8'h0);
      chk("arb.slot", 8'(bus.slot), 8'(k));
      @(posedge clk);
      @(negedge clk);
      e = sb_q.pop_front();
      chk("issue.grant", 8'(bus.grant), 8'(e.g));
      chk("issue.blocked", 8'(bus.blocked), 8'(e.b));
      chk("issue.out_vld", 8'(bus.out_vld), 8'(e.ov));
      chk("issue.out_sel", bus.out_sel, e.os);
      chk("issue.slot", 8'(bus.slot), 8'(k));
      chk("issue.frame_done", 8'(bus.frame_done), 8'h0);
      if (k == abort_at) begin
        bus.abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.abort = 1'b0;
        chk_idle("abort");
        return;
      end
      if (k == 1 && abort_at < 0) bus.start = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    chk("done.frame_done", 8'(bus.frame_done), 8'h1);
    chk("done.busy", 8'(bus.busy), 8'h1);
    chk("done.grant", 8'(bus.grant), 8'h0);
    @(posedge clk);
    @(negedge clk);
    chk_idle("end");
    @(posedge clk);
    @(negedge clk);
    chk("no_queued_start.busy", 8'(bus.busy), 8'h0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.req_valid = 4'h0;
    bus.req_dest = 8'h0;
    tbl[0] = mk(4'b1111, 8'h1B, 4'b1111, 4'b0000, 4'b1111, 8'h1B);
    tbl[1] = mk(4'b0000, 8'h1B, 4'b0000, 4'b0000, 4'b0000, 8'h00);
    tbl[2] = mk(4'b0101, 8'h31, 4'b0101, 4'b0000, 4'b1010, 8'h80);
    tbl[3] = mk(4'b1000, 8'h00, 4'b1000, 4'b0000, 4'b0001, 8'h03);
    tbl[4] = mk(4'b1111, 8'hE4, 4'b1111, 4'b0000, 4'b1111, 8'hE4);
    tbl[5] = mk(4'b0010, 8'h08, 4'b0010, 4'b0000, 4'b0100, 8'h10);
    tbl[6] = mk(4'b0110, 8'h30, 4'b0110, 4'b0000, 4'b1001, 8'h81);
    tbl[7] = mk(4'b0000, 8'hFF, 4'b0000, 4'b0000, 4'b0000, 8'h00);
    repeat (2) @(negedge clk);
    chk_idle("reset_hold");
    rst = 1'b0;
    @(negedge clk);
    chk_idle("reset");
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk_idle("start_abort");
    for (int k = 0; k < NS; k++) frm[k] = cont(cw(k, 0));
    run_frame(-1);
    for (int k = 0; k < NS; k++) frm[k] = cont(cw(k, 0));
    run_frame(1);
    for (int k = 0; k < NS; k++) frm[k] = cont(cw(k, 2));
    run_frame(-1);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.req_valid = 4'hf;
    bus.req_dest = 8'h1B;
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst.grant", 8'(bus.grant), 8'h0F);
    #2 rst = 1'b1;
    #1 chk_idle("async_rst");
    @(negedge clk);
    rst = 1'b0;
    chk_idle("post_rst");
    for (int k = 0; k < NS; k++) frm[k] = cont(cw(k, 0));
    run_frame(-1);
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < NS; k++) frm[k] = tbl[4*f + k];
      run_frame(-1);
    end
    chk("scoreboard_empty", 8'(sb_q.size()), 8'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/xbar_slot_scheduler.md
# xbar_slot_scheduler

- Per-frame slot scheduler and output arbiter for the 4x4 packet crossbar.
- A frame has NUM_SLOTS slots. In each slot it:
  - samples the four input ports' valid/destination fields;
  - resolves output contention (round-robin or fixed priority);
  - issues a conflict-free grant set plus per-output source selects.
- Sits between the input port buffers and the crossbar fabric. Its out_sel/out_vld drive the fabric's slot-select inputs; its grant lines pop the input buffers.

## Interface
- NUM_SLOTS, 4, slots per frame (legal 1..16).
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin a frame; honoured only in IDLE.
- abort  in  1  synchronous frame abort.
- req_valid  in  4  bit i: input i holds a packet (packet bit 14).
- req_dest  in  8  [2i+1:2i]: destination output of input i (packet bits 12:11).
- grant  out  4  bit i: input i wins the current slot; registered.
- blocked  out  4  bit i: input i requested but lost the current slot; registered.
- out_vld  out  4  bit o: output o carries a packet this slot.
- out_sel  out  8  [2o+1:2o]: input index routed to output o.
- slot  out  4  current slot index.
- busy  out  1  frame in progress (ARB, ISSUE, DONE).
- frame_done  out  1  one-cycle pulse at end of a completed frame.

## Operation
- States and transitions:
  - IDLE→ARB on start & ~abort.
  - ARB→ISSUE.
  - ISSUE→ARB with slot+1 if slot<NUM_SLOTS-1, else ISSUE→DONE.
  - DONE→IDLE.
  - Any non-IDLE state with abort→IDLE.
- ARB cycle: for each output o, candidates = {i : req_valid[i] & req_dest[i]==o}. One winner per output is chosen and registered into grant/out_sel/out_vld/blocked at the ARB→ISSUE edge.
- Each input names exactly one destination, so at most one grant per input and one winner per output.
- blocked = req_valid & ~grant, sampled in the same ARB cycle.
- Outside ISSUE: grant, blocked, out_vld = 0 and out_sel = 0.
- A requester seeing grant during ISSUE must present its next packet (or deassert req_valid) before the next ARB cycle. The scheduler does not track consumption.
- Round-robin pointers ptr[o] (2 bits each, one per output; present only with the macro):
  - The search starts at ptr[o] and wraps 3→0.
  - On a grant to input w, ptr[o] ← (w+1) mod 4.
  - No grant leaves ptr[o] unchanged.
  - Pointers persist across frames and aborts; only rst clears them.
- slot is 0 in IDLE and is cleared on start. It wraps only via DONE→IDLE, never past NUM_SLOTS-1.

## Timing
- Reset values:
  - state IDLE, slot 0, ptr[*] 0;
  - grant, blocked, out_vld, out_sel, busy, frame_done all 0.
- Frame cycle counts, with start sampled at edge E0:
  - ARB occupies the cycle after E0.
  - Slot k ISSUE follows edge E(2k+1).
  - DONE follows E(2·NUM_SLOTS); frame_done = 1 for exactly that cycle.
  - IDLE (busy = 0) follows E(2·NUM_SLOTS+1).
- Arbitration latency: requests sampled in ARB appear as grants one cycle later. Grants are held exactly one cycle.
- start while busy is ignored, and no frame is queued. start & abort together in IDLE: stays IDLE.
- abort asserted in ISSUE:
  - grant/out_vld clear at the next edge;
  - pointer updates for that slot are already committed;
  - no frame_done.
- abort in DONE: frame_done deasserts next edge, identical to the normal DONE→IDLE path.
- rst mid-frame: all outputs clear immediately (asynchronous); no partial grant survives.

## Configuration
- XBAR_SCHED_RR_EN defined: round-robin per output using ptr[o], as above.
- XBAR_SCHED_RR_EN undefined: fixed priority. The lowest-numbered candidate input wins; no pointer registers are built. All other behaviour and timing are unchanged.

## Test plan
- No contention: req_valid = 1111, dests 3,2,1,0 → every ISSUE has grant = 1111, blocked = 0000, out_vld = 1111, out_sel = {o3:0, o2:1, o1:2, o0:3}.
- RR contention (macro on): all four inputs dest 2, held for the whole frame → slot 0..3 grant = 0001, 0010, 0100, 1000; out_sel[5:4] = 0,1,2,3; blocked = complement of grant.
- Fixed priority (macro off): same stimulus → grant = 0001 and blocked = 1110 in all four slots.
- Frame timing (NUM_SLOTS=4): start at E0 → grants after E1, E3, E5, E7; frame_done high only after E8; busy low after E9. A start pulsed at E3 is ignored.
- Abort: abort during slot-1 ISSUE → IDLE next cycle with no frame_done. A new frame with all inputs dest 2 first grants input 2 (pointer retained).
- Async reset mid-frame: rst asserted during ISSUE with grant = 1111 → all outputs 0 without a clock edge; ptr back to 0 (the next RR frame grants input 0 first).
